// File: rtl/regfile_scoreboard_if.sv
// Issue, read and writeback signals between the pipeline and the register file.
// The master side is the pipeline; the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            hazard;
    logic            we;
    logic [AW-1:0]   wr_rd;
    logic [XLEN-1:0] write_data;
    logic [AW:0]     busy_count;

    modport master (
        output rs1, rs2, use_rs1, use_rs2, issue_valid, issue_rd, we, wr_rd, write_data,
        input  read_data1, read_data2, issue_ready, hazard, busy_count
    );

    modport slave (
        input  rs1, rs2, use_rs1, use_rs2, issue_valid, issue_rd, we, wr_rd, write_data,
        output read_data1, read_data2, issue_ready, hazard, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass and a per-register busy
// scoreboard that flags RAW/WAW hazards to the issue stage.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_scoreboard_if.slave   bus
);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    busy_count_q;
    logic [CW-1:0]    busy_count_d;

    logic             wr_en;
    logic [NREGS-1:0] wr_onehot;
    logic [NREGS-1:0] eff_busy;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             haz_rd;
    logic             hazard_c;
    logic             ready_c;
    logic             set_en;
    logic             inc;
    logic             dec;

    // A register being written back this cycle is no longer a hazard.
    always_comb begin
        wr_en     = bus.we && (bus.wr_rd != '0);
        wr_onehot = '0;
        if (wr_en) begin
            wr_onehot[bus.wr_rd] = 1'b1;
        end
        eff_busy  = busy_q & ~wr_onehot;
    end

    // Asynchronous read ports with same-cycle writeback bypass.
    always_comb begin
        bus.read_data1 = regs_q[bus.rs1];
        if (bus.rs1 == '0) begin
            bus.read_data1 = '0;
        end else if (wr_en && (bus.wr_rd == bus.rs1)) begin
            bus.read_data1 = bus.write_data;
        end

        bus.read_data2 = regs_q[bus.rs2];
        if (bus.rs2 == '0) begin
            bus.read_data2 = '0;
        end else if (wr_en && (bus.wr_rd == bus.rs2)) begin
            bus.read_data2 = bus.write_data;
        end
    end

    always_comb begin
        haz_rs1  = bus.use_rs1     && (bus.rs1 != '0)      && eff_busy[bus.rs1];
        haz_rs2  = bus.use_rs2     && (bus.rs2 != '0)      && eff_busy[bus.rs2];
        haz_rd   = bus.issue_valid && (bus.issue_rd != '0) && eff_busy[bus.issue_rd];
        hazard_c = haz_rs1 || haz_rs2 || haz_rd;
        ready_c  = bus.issue_valid && !hazard_c;

        bus.hazard      = hazard_c;
        bus.issue_ready = ready_c;
        bus.busy_count  = busy_count_q;
    end

    // Reserve is applied after release so a same-index pair leaves the bit set.
    always_comb begin
        set_en = ready_c && (bus.issue_rd != '0);
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[bus.wr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        inc = set_en && !busy_q[bus.issue_rd];
        dec = wr_en && busy_q[bus.wr_rd] && !(set_en && (bus.issue_rd == bus.wr_rd));

        busy_count_d = busy_count_q;
        case ({inc, dec})
            2'b10:   busy_count_d = busy_count_q + CW'(1);
            2'b01:   busy_count_d = busy_count_q - CW'(1);
            default: busy_count_d = busy_count_q;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.wr_rd] = bus.write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: hand sequences for reset
// behaviour plus a vector table checked through an expectation queue.
module tb_regfile_scoreboard;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic clk;
    logic reset;

    regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        iv;
        logic [4:0]  ird;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_haz;
        logic        e_rdy;
        logic [5:0]  e_cnt;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t table_v [$];
    vec_t exp_q   [$];

    function automatic vec_t mk(input int id,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic iv, input logic [4:0] ird,
                                input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic eh, input logic er, input logic [5:0] ec);
        vec_t v;
        v.id = id; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.iv = iv; v.ird = ird; v.we = we; v.wrd = wrd; v.wd = wd;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_haz = eh; v.e_rdy = er; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.rs1 = '0; bus.rs2 = '0; bus.use_rs1 = 1'b0; bus.use_rs2 = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.we = 1'b0; bus.wr_rd = '0; bus.write_data = '0;
    endtask

    // Drive one vector after the falling edge, check just before the rising edge.
    task automatic apply(input vec_t v);
        vec_t e;
        string n;
        @(negedge clk);
        bus.rs1 = v.rs1; bus.use_rs1 = v.u1; bus.rs2 = v.rs2; bus.use_rs2 = v.u2;
        bus.issue_valid = v.iv; bus.issue_rd = v.ird;
        bus.we = v.we; bus.wr_rd = v.wrd; bus.write_data = v.wd;
        exp_q.push_back(v);
        #4;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: expectation queue empty");
        end else begin
            e = exp_q.pop_front();
            n = $sformatf("vec%0d", e.id);
            chk({n, ".read_data1"}, bus.read_data1, e.e_rd1);
            chk({n, ".read_data2"}, bus.read_data2, e.e_rd2);
            chk({n, ".hazard"}, 32'(bus.hazard), 32'(e.e_haz));
            chk({n, ".issue_ready"}, 32'(bus.issue_ready), 32'(e.e_rdy));
            chk({n, ".busy_count"}, 32'(bus.busy_count), 32'(e.e_cnt));
        end
    endtask

    initial begin
        //                 id rs1 u1 rs2 u2 iv ird we wrd wd            e_rd1         e_rd2         h  r  cnt
        table_v.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0));
        table_v.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        table_v.push_back(mk( 2, 0, 0, 5, 0, 0, 0, 1, 5, 32'h12345678, 32'h0,        32'h12345678, 0, 0, 0));
        table_v.push_back(mk( 3, 5, 0, 5, 0, 0, 0, 0, 0, 32'h0,        32'h12345678, 32'h12345678, 0, 0, 0));
        table_v.push_back(mk( 4, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        table_v.push_back(mk( 5, 7, 1, 0, 0, 1, 8, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1));
        table_v.push_back(mk( 6, 7, 1, 0, 0, 0, 0, 1, 7, 32'hA5,       32'hA5,       32'h0,        0, 0, 1));
        table_v.push_back(mk( 7, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'hA5,       32'h0,        0, 0, 0));
        table_v.push_back(mk( 8, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        table_v.push_back(mk( 9, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1));
        table_v.push_back(mk(10, 9, 0, 9, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1));
        table_v.push_back(mk(11, 0, 0, 9, 0, 1, 9, 1, 9, 32'h99,       32'h0,        32'h99,       0, 1, 1));
        table_v.push_back(mk(12, 0, 0, 9, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h99,       1, 0, 1));
        table_v.push_back(mk(13, 0, 0, 9, 1, 0, 0, 1, 9, 32'h1234,     32'h0,        32'h1234,     0, 0, 1));
        table_v.push_back(mk(14, 0, 0, 0, 0, 0, 0, 1, 9, 32'h55,       32'h0,        32'h0,        0, 0, 0));
        table_v.push_back(mk(15, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h55,       32'h0,        0, 0, 0));
        table_v.push_back(mk(16, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        table_v.push_back(mk(17, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        table_v.push_back(mk(18, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        table_v.push_back(mk(19, 3, 0, 0, 0, 1, 4, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1));
        table_v.push_back(mk(20, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 2));
        table_v.push_back(mk(21, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 3));
        table_v.push_back(mk(22, 0, 0, 5, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h12345678, 1, 0, 3));

        // Reset state: outputs follow with no stored state.
        idle();
        reset = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.rs1 = 5'd5;
        @(negedge clk);
        #1;
        chk("reset.busy_count", 32'(bus.busy_count), 32'd0);
        chk("reset.hazard", 32'(bus.hazard), 32'd0);
        chk("reset.issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("reset.read_data1", bus.read_data1, 32'd0);
        idle();
        reset = 1'b0;

        // Pre-write every register, then reset for one cycle.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            bus.we = 1'b1; bus.wr_rd = 5'(i); bus.write_data = 32'(i) * 32'h01010101;
        end
        @(negedge clk);
        idle();
        bus.rs1 = 5'd31; bus.rs2 = 5'd1;
        #1;
        chk("prewrite.x31", bus.read_data1, 32'h1F1F1F1F);
        chk("prewrite.x1", bus.read_data2, 32'h01010101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            bus.rs1 = 5'(i); bus.rs2 = 5'(32 - i);
            #1;
            chk($sformatf("cleared.rd1.x%0d", i), bus.read_data1, 32'd0);
            chk($sformatf("cleared.rd2.x%0d", 32 - i), bus.read_data2, 32'd0);
        end
        chk("cleared.busy_count", 32'(bus.busy_count), 32'd0);
        chk("cleared.hazard", 32'(bus.hazard), 32'd0);

        foreach (table_v[k]) apply(table_v[k]);

        // Mid-operation reset with x3..x5 reserved and a writeback in flight.
        @(negedge clk);
        idle();
        bus.we = 1'b1; bus.wr_rd = 5'd6; bus.write_data = 32'h66;
        bus.use_rs1 = 1'b1; bus.rs1 = 5'd4;
        reset = 1'b1;
        #1;
        chk("midreset.busy_count", 32'(bus.busy_count), 32'd0);
        chk("midreset.hazard", 32'(bus.hazard), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.we = 1'b0;
        #1;
        chk("postreset.hazard_x4", 32'(bus.hazard), 32'd0);
        chk("postreset.busy_count", 32'(bus.busy_count), 32'd0);
        chk("postreset.x4", bus.read_data1, 32'd0);
        bus.rs1 = 5'd6; bus.rs2 = 5'd5;
        #1;
        chk("postreset.x6_discarded", bus.read_data1, 32'd0);
        chk("postreset.x5", bus.read_data2, 32'd0);
        @(negedge clk);
        #1;
        chk("postreset.x6_after_edge", bus.read_data1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the pipelined core; successor to the single-cycle register file.
- Two asynchronous read ports with write-to-read bypass, one synchronous write port, register 0 hardwired to zero.
- Integrated per-register busy scoreboard: issue stage reserves a destination, writeback releases it.
- Block raises hazard/stall toward the issue stage and reports the outstanding-write count.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >= 2).
- AW, 5, register index width; must equal log2(NREGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- rs1  in  AW  read port 1 index.
- rs2  in  AW  read port 2 index.
- use_rs1  in  1  issuing instruction reads rs1.
- use_rs2  in  1  issuing instruction reads rs2.
- read_data1  out  XLEN  read port 1 data (combinational).
- read_data2  out  XLEN  read port 2 data (combinational).
- issue_valid  in  1  issue stage requests to reserve issue_rd.
- issue_rd  in  AW  destination being reserved.
- issue_ready  out  1  reservation accepted this cycle.
- hazard  out  1  RAW or WAW conflict; issue stage must stall.
- we  in  1  writeback write enable.
- wr_rd  in  AW  writeback destination index.
- write_data  in  XLEN  writeback data.
- busy_count  out  AW+1  number of registers currently reserved.

Behaviour:
- Reset (async, active-high): all NREGS registers -> 0, all busy bits -> 0, busy_count -> 0. Combinational outputs follow: read data 0, hazard 0, issue_ready = issue_valid.
- Write: on rising edge with we=1 and wr_rd!=0, regs[wr_rd] <= write_data. we=0 or wr_rd=0: no write. Register 0 is never stored.
- Read: read_dataN = 0 if rsN=0. Else, if we=1 and wr_rd=rsN, read_dataN = write_data (same-cycle bypass). Else read_dataN = regs[rsN].
- Busy scoreboard: one bit per register; busy[0] is constant 0.
- Release: edge with we=1, wr_rd!=0 clears busy[wr_rd]. Writing a non-busy register is legal and leaves it clear.
- Effective busy for hazard purposes is busy[i] & ~(we & wr_rd==i). A register being written back this cycle is not a hazard; its value arrives via bypass.
- hazard = (use_rs1 & rs1!=0 & effbusy[rs1]) | (use_rs2 & rs2!=0 & effbusy[rs2]) | (issue_valid & issue_rd!=0 & effbusy[issue_rd]).
- issue_ready = issue_valid & ~hazard. Combinational, zero latency.
- Reserve: edge with issue_ready=1 and issue_rd!=0 sets busy[issue_rd]. issue_rd=0 is accepted but sets nothing.
- Simultaneous release and reserve of the same index in one cycle: reserve wins, busy stays 1.
- busy_count is a registered popcount of the busy bits. It is updated each edge by +1 for a set, -1 for a clear, and net 0 for a same-index set/clear. It never exceeds NREGS-1 and never underflows.
- Reset asserted mid-operation: all state clears immediately. Pending reservations are lost, and the writeback on that edge is discarded.
- No read latency; write-to-architectural-state latency is 1 cycle.

Test Plan:
- Reset with regs pre-written, then reset=1 for 1 cycle -> read x1..x31 = 0, busy_count=0, hazard=0.
- we=1, wr_rd=0, write_data=0xDEADBEEF; next cycle rs1=0 -> read_data1=0, busy_count unchanged.
- Bypass: we=1, wr_rd=5, write_data=0x12345678, rs2=5 same cycle -> read_data2=0x12345678. Next cycle, with we=0, read_data2 is still 0x12345678.
- Reserve x7 (issue_valid=1, issue_rd=7) -> issue_ready=1, next cycle busy_count=1. Then use_rs1=1, rs1=7 -> hazard=1, issue_ready=0 for a new issue. Writeback x7=0xA5 -> hazard=0 that cycle, read_data1=0xA5, busy_count=0 after edge.
- WAW: x9 busy, issue_valid=1, issue_rd=9 -> hazard=1, busy_count stays 1. In the same cycle as writeback of x9 -> issue_ready=1, busy[9] remains 1, busy_count remains 1.
- Reserve x3, x4, x5 on consecutive cycles (busy_count=3), then assert reset between edges -> busy_count=0 immediately; a subsequent use of x4 gives hazard=0.
